// File: rtl/mul_unit.sv
// Iterative RV32M multiplier (MUL/MULH/MULHSU/MULHU) driving the hazard-unit counter.
// Optional build macro MUL_KILL_EN enables the kill input (EX flush abort).
module mul_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        mul,
    input  logic [2:0]  funct3,
    input  logic [31:0] rs1_val,
    input  logic [31:0] rs2_val,
    input  logic        kill,
    output logic [2:0]  counter,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_NEG  = 3'd5;
    localparam logic [2:0] S_OUT6 = 3'd6;
    localparam logic [2:0] S_OUT7 = 3'd7;

    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic        sign;
    logic [63:0] acc;
    logic [31:0] out_reg;

    logic [2:0]  term_cnt;
    logic        signed_a;
    logic        signed_b;
    logic        neg_a;
    logic        neg_b;
    logic [31:0] a_abs;
    logic [31:0] b_abs;
    logic [1:0]  digit_idx;
    logic [7:0]  digit;
    logic [39:0] pp;
    logic [63:0] pp_shifted;

    // funct3[2] is always 0 for multiplies; it carries no information here.
    logic unused_funct3_b2;
    assign unused_funct3_b2 = funct3[2];

    assign term_cnt = funct3[1] ? S_OUT7 : S_OUT6;
    assign busy     = (counter != S_IDLE);
    assign done     = (counter == term_cnt);

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        signed_a   = funct3[1] ^ funct3[0];
        signed_b   = (funct3[1:0] == 2'b01);
        neg_a      = signed_a & rs1_val[31];
        neg_b      = signed_b & rs2_val[31];
        a_abs      = neg_a ? (32'd0 - rs1_val) : rs1_val;
        b_abs      = neg_b ? (32'd0 - rs2_val) : rs2_val;
        digit_idx  = counter[1:0] - 2'd1;
        digit      = b_mag[{digit_idx, 3'b000} +: 8];
        pp         = {8'd0, a_mag} * {32'd0, digit};
        pp_shifted = {24'd0, pp} << {digit_idx, 3'b000};
    end

    always_comb begin
        result = 32'd0;
        if (done) begin
            if (counter == S_OUT7)
                result = out_reg;
            else
                result = funct3[0] ? acc[63:32] : acc[31:0];
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; the datapath
    // registers are reset too so the result is never driven from stale data.
    always_ff @(posedge clk) begin
        if (reset) begin
            counter <= S_IDLE;
            a_mag   <= 32'd0;
            b_mag   <= 32'd0;
            sign    <= 1'b0;
            acc     <= 64'd0;
            out_reg <= 32'd0;
        end
`ifdef MUL_KILL_EN
        else if (kill) begin
            counter <= S_IDLE;
            acc     <= 64'd0;
        end
`endif
        else begin
            case (counter)
                S_IDLE: begin
                    if (mul) begin
                        a_mag   <= a_abs;
                        b_mag   <= b_abs;
                        sign    <= neg_a ^ neg_b;
                        acc     <= 64'd0;
                        counter <= 3'd1;
                    end
                end
                S_NEG: begin
                    if (sign)
                        acc <= 64'd0 - acc;
                    counter <= S_OUT6;
                end
                S_OUT6: begin
                    if (term_cnt == S_OUT6) begin
                        counter <= S_IDLE;
                    end else begin
                        out_reg <= acc[63:32];
                        counter <= S_OUT7;
                    end
                end
                S_OUT7: begin
                    counter <= S_IDLE;
                end
                default: begin
                    // Counter 1..4: one 8-bit digit of |B| per cycle, LSB first.
                    acc     <= acc + pp_shifted;
                    counter <= counter + 3'd1;
                end
            endcase
        end
    end

`ifndef MUL_KILL_EN
    logic unused_kill;
    assign unused_kill = kill;
`endif

endmodule

// File: tb/tb_mul_unit.sv
// Self-checking bench for mul_unit: directed cases plus random operations
// checked against a plain-arithmetic product model.
module tb_mul_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        mul;
    logic [2:0]  funct3;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic        kill;
    logic [2:0]  counter;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks   = 0;
    int failures = 0;

    mul_unit dut (
        .clk     (clk),
        .reset   (reset),
        .mul     (mul),
        .funct3  (funct3),
        .rs1_val (rs1_val),
        .rs2_val (rs2_val),
        .kill    (kill),
        .counter (counter),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: exact 64-bit product of the operands as the instruction interprets them.
    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] b);
        logic [63:0] a64;
        logic [63:0] b64;
        logic [63:0] p;
        case (f3[1:0])
            2'b01:   begin a64 = {{32{a[31]}}, a}; b64 = {{32{b[31]}}, b}; end
            2'b10:   begin a64 = {{32{a[31]}}, a}; b64 = {32'd0, b};       end
            default: begin a64 = {32'd0, a};       b64 = {32'd0, b};       end
        endcase
        p = a64 * b64;
        return (f3[1:0] == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 4))
            0:       return 32'h8000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h0000_0000;
            default: return $urandom;
        endcase
    endfunction

    // Issue one multiply from counter=0 and follow it through to the return to idle.
    task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input bit hold_mul);
        int          lat;
        logic [31:0] exp;
        lat     = f3[1] ? 7 : 6;
        exp     = ref_result(f3, a, b);
        mul     = 1'b1;
        funct3  = f3;
        rs1_val = a;
        rs2_val = b;
        for (int k = 1; k <= lat; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("counter f3=%0d k=%0d", f3, k), {61'd0, counter}, 64'(k));
            check($sformatf("done f3=%0d k=%0d", f3, k), {63'd0, done}, {63'd0, (k == lat)});
            check($sformatf("result f3=%0d k=%0d", f3, k), {32'd0, result},
                  (k == lat) ? {32'd0, exp} : 64'd0);
            rs1_val = $urandom;
            rs2_val = $urandom;
        end
        if (!hold_mul)
            mul = 1'b0;
        @(posedge clk);
        #1;
        check("idle counter", {61'd0, counter}, 64'd0);
        check("idle busy", {63'd0, busy}, 64'd0);
        check("idle done", {63'd0, done}, 64'd0);
        check("idle result", {32'd0, result}, 64'd0);
    endtask

    initial begin
        logic [31:0] exp_v;
        reset   = 1'b1;
        mul     = 1'b0;
        kill    = 1'b0;
        funct3  = 3'd0;
        rs1_val = 32'd0;
        rs2_val = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset counter", {61'd0, counter}, 64'd0);
        check("reset busy", {63'd0, busy}, 64'd0);
        check("reset done", {63'd0, done}, 64'd0);
        check("reset result", {32'd0, result}, 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("stay idle", {61'd0, counter}, 64'd0);

        // Directed cases from the plan.
        do_op(3'b000, 32'd7, 32'hFFFF_FFFD, 1'b0);
        do_op(3'b001, 32'h8000_0000, 32'h8000_0000, 1'b0);
        do_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        do_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        do_op(3'b000, 32'd3, 32'd5, 1'b0);

        // Reset in the middle of a MULHU.
        mul     = 1'b1;
        funct3  = 3'b011;
        rs1_val = 32'hFFFF_FFFF;
        rs2_val = 32'hFFFF_FFFF;
        repeat (3) @(posedge clk);
        #1;
        check("pre-reset counter", {61'd0, counter}, 64'd3);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("mid reset counter", {61'd0, counter}, 64'd0);
        check("mid reset done", {63'd0, done}, 64'd0);
        check("mid reset result", {32'd0, result}, 64'd0);
        reset = 1'b0;
        mul   = 1'b0;
        do_op(3'b000, 32'd2, 32'd2, 1'b0);

        // Kill at counter=4.
        mul     = 1'b1;
        funct3  = 3'b000;
        rs1_val = 32'h0000_1234;
        rs2_val = 32'h0000_5678;
        exp_v   = ref_result(3'b000, 32'h0000_1234, 32'h0000_5678);
        repeat (4) @(posedge clk);
        #1;
        check("pre-kill counter", {61'd0, counter}, 64'd4);
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
`ifdef MUL_KILL_EN
        mul = 1'b0;
        check("kill counter", {61'd0, counter}, 64'd0);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            check("post-kill done", {63'd0, done}, 64'd0);
            check("post-kill counter", {61'd0, counter}, 64'd0);
        end
        // Kill together with a fresh mul: capture slips by one cycle.
        mul     = 1'b1;
        kill    = 1'b1;
        funct3  = 3'b000;
        rs1_val = 32'd9;
        @(posedge clk);
        #1;
        kill = 1'b0;
        check("kill+mul counter", {61'd0, counter}, 64'd0);
        do_op(3'b000, 32'd9, 32'd11, 1'b0);
`else
        check("kill ignored counter", {61'd0, counter}, 64'd5);
        @(posedge clk);
        #1;
        check("kill ignored done", {63'd0, done}, 64'd1);
        check("kill ignored result", {32'd0, result}, {32'd0, exp_v});
        mul = 1'b0;
        @(posedge clk);
        #1;
        check("kill ignored idle", {61'd0, counter}, 64'd0);
`endif

        // Kill in the done cycle: done still reported, counter returns to 0.
        mul     = 1'b1;
        funct3  = 3'b011;
        rs1_val = 32'hDEAD_BEEF;
        rs2_val = 32'h1234_5678;
        exp_v   = ref_result(3'b011, 32'hDEAD_BEEF, 32'h1234_5678);
        repeat (7) @(posedge clk);
        #1;
        kill = 1'b1;
        #1;
        check("kill@done counter", {61'd0, counter}, 64'd7);
        check("kill@done done", {63'd0, done}, 64'd1);
        check("kill@done result", {32'd0, result}, {32'd0, exp_v});
        mul = 1'b0;
        @(posedge clk);
        #1;
        kill = 1'b0;
        check("kill@done next counter", {61'd0, counter}, 64'd0);

        // Random operations, some back-to-back.
        for (int n = 0; n < 40; n++) begin
            logic [2:0]  f3;
            logic [31:0] a;
            logic [31:0] b;
            f3 = 3'($urandom_range(0, 3));
            a  = pick_operand();
            b  = pick_operand();
            do_op(f3, a, b, bit'($urandom_range(0, 1)));
        end
        mul = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mul_unit.md
# mul_unit

Iterative RV32M multiplier in the EX stage. It produces the `mul`/`counter` pair that the hazard detection unit uses to hold PC, IF/ID and ID/EX while a multiply is in flight. It computes MUL, MULH, MULHSU and MULHU over 32-bit operands. The result is valid in exactly the cycle the hazard unit releases the stall: counter 6 when funct3[1]=0, counter 7 when funct3[1]=1.

## Interface

Parameters:
- none

Ports:
- `clk` input 1 — pipeline clock.
- `reset` input 1 — synchronous, active-high.
- `mul` input 1 — ID/EX holds a valid M-extension multiply; held high by the stall for the whole operation.
- `funct3` input 3 — 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU; bit 2 must be 0.
- `rs1_val` input 32 — forwarded operand A, sampled only at counter=0.
- `rs2_val` input 32 — forwarded operand B, sampled only at counter=0.
- `kill` input 1 — abort the current operation (EX flush).
- `counter` output 3 — progress count; fed to the hazard unit.
- `busy` output 1 — operation in progress (counter != 0).
- `done` output 1 — result valid this cycle.
- `result` output 32 — product word; 0 when `done`=0.

## Operation

- Terminal count: T=6 when funct3[1]=0, T=7 when funct3[1]=1. T is decoded from `funct3` each cycle; ID/EX holds `funct3` stable during a stall.
- Sign rules:
  - A is signed for MULH and MULHSU.
  - B is signed for MULH only.
  - MUL takes the low word; the sign treatment does not affect it.
- Datapath: magnitude multiply with a 64-bit accumulator. B magnitude is consumed 8 bits per cycle, LSB digit first.
- Counter states:
  - 0 (IDLE): if `mul` is high, capture |A|, |B|, sign = sA XOR sB, clear the accumulator, go to 1.
  - 1–4 (ACC): acc += |A| × digit[counter-1] << 8·(counter-1), 32×8 partial product.
  - 5 (NEG): acc = sign ? −acc : acc, 64-bit two's complement.
  - 6 (OUT6): if T=6, `done`=1 and `result` = funct3[0] ? acc[63:32] : acc[31:0], next state 0. Otherwise acc is copied to the output register and the next state is 7.
  - 7 (OUT7): `done`=1, `result` = acc[63:32], next state 0.
- In the `done` cycle the pipeline advances. The counter always returns to 0 next, even if `mul` stays high: that is a new instruction, and it starts at counter=0 in the following cycle.
- `mul` low while counter is 0: stay idle. `mul` low mid-operation is illegal unless `kill` is also asserted.
- Magnitude of 0x80000000 is 0x80000000 treated as unsigned; no overflow is possible in 64 bits.

## Timing

- Reset values: `counter`=0, `busy`=0, `done`=0, `result`=0, accumulator=0, sign=0.
- Reset mid-operation: next cycle is idle with all outputs at their reset values. Reset wins over `mul` and `kill`.
- Latency from `mul` rising with counter=0: `done` asserts 6 clocks later for MUL/MULH and 7 clocks later for MULHSU/MULHU.
- Issue rate: back-to-back multiplies issue with 0 dead cycles between `done` and the next capture.
- `done` is combinational from `counter` and `funct3`. `result` is driven from the registered accumulator or output register; there is no combinational path from `rs1_val`/`rs2_val` to `result`.
- `kill` together with `done` in the same cycle: `done` is still reported, and the counter returns to 0.

## Configuration

- `MUL_KILL_EN` defined:
  - `kill` high forces counter to 0 and accumulator to 0 next cycle.
  - Suppresses `done` in that cycle, except in the `done` cycle itself, per Timing.
  - `kill` and a fresh `mul` together: kill wins; capture happens one cycle later.
- `MUL_KILL_EN` undefined:
  - `kill` is ignored.
  - Flush of an in-flight multiply relies solely on `reset`.

## Test plan

- MUL, rs1=7, rs2=0xFFFFFFFD → counter steps 1..6; `done` only at counter=6; `result`=0xFFFFFFEB; counter=0 next cycle.
- MULH, rs1=rs2=0x80000000 → `done` at counter=6; `result`=0x40000000.
- MULHU, rs1=rs2=0xFFFFFFFF → counter reaches 7; `done` at 7 only; `result`=0xFFFFFFFE.
- MULHSU, rs1=0xFFFFFFFF, rs2=0xFFFFFFFF → `result`=0xFFFFFFFF at counter=7. Follow immediately with MUL 3×5 (`mul` held high) → next capture at counter=0; `result`=15 six clocks later.
- Reset at counter=3 of MULHU → next cycle counter=0, `done`=0, `result`=0. A new MUL 2×2 then yields 4 at counter=6.
- With `MUL_KILL_EN`: `kill` at counter=4 → counter=0 next cycle; no `done` pulse. Without `MUL_KILL_EN`: same stimulus completes normally.
